// File: rtl/cpu2_pkg.sv
// ============================================================================
//  Module   : cpu2_pkg
//  Brief    : Shared opcodes, instruction width and loader state encoding.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package cpu2_pkg;

    localparam int WORD_W = 2;

    localparam logic [WORD_W-1:0] OP_INC = 2'b00;
    localparam logic [WORD_W-1:0] OP_JNO = 2'b01;
    localparam logic [WORD_W-1:0] OP_HLT = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_CHECK = 3'd2,
        ST_DONE  = 3'd3,
        ST_ERROR = 3'd4
    } loader_state_t;

endpackage

`default_nettype wire

// File: rtl/prog_loader_if.sv
// ============================================================================
//  Module   : prog_loader_if
//  Brief    : Serial program input, RAM write port and loader status bundle.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface prog_loader_if #(
    parameter int ADDR_W = 2
);
    import cpu2_pkg::*;

    logic              start;
    logic              ser_bit;
    logic              ser_valid;
    logic              ser_ready;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [WORD_W-1:0] wr_data;
    logic              busy;
    logic              done;
    logic              error;
    logic              cpu_run;

    modport master (
        output start, ser_bit, ser_valid,
        input  ser_ready, wr_en, wr_addr, wr_data, busy, done, error, cpu_run
    );

    modport slave (
        input  start, ser_bit, ser_valid,
        output ser_ready, wr_en, wr_addr, wr_data, busy, done, error, cpu_run
    );

endinterface

`default_nettype wire

// File: rtl/prog_loader_deser.sv
// ============================================================================
//  Module   : prog_loader_deser
//  Brief    : Collects two serial bits (LSB first) into one instruction word.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module prog_loader_deser
    import cpu2_pkg::*;
(
    input  wire logic              clock,
    input  wire logic              reset_n,
    input  wire logic              i_clear,
    input  wire logic              i_bit,
    input  wire logic              i_bit_en,
    output logic                   o_word_valid,
    output logic [WORD_W-1:0]      o_word
);

    logic r_have_lsb;
    logic r_lsb;

    always_ff @(posedge clock) begin
        if (!reset_n || i_clear) begin
            r_have_lsb <= 1'b0;
            r_lsb      <= 1'b0;
        end else if (i_bit_en) begin
            if (r_have_lsb) begin
                r_have_lsb <= 1'b0;
            end else begin
                r_lsb      <= i_bit;
                r_have_lsb <= 1'b1;
            end
        end
    end

    // Word completes combinationally with the second bit so the top can register it on that edge
    assign o_word_valid = i_bit_en & r_have_lsb;
    assign o_word       = {i_bit, r_lsb};

endmodule

`default_nettype wire

// File: rtl/prog_loader.sv
// ============================================================================
//  Module   : prog_loader
//  Brief    : Loads a bit-serial program into the instruction RAM and releases
//             the CPU when done. Optional checksum word: PROG_LOADER_CHECKSUM_EN.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module prog_loader
    import cpu2_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 2
)(
    input  wire logic      clock,
    input  wire logic      reset_n,
    prog_loader_if.slave   bus
);

    localparam int                 c_CNT_W     = $clog2(DEPTH + 1);
    localparam logic [c_CNT_W-1:0] c_DEPTH_CNT = c_CNT_W'(DEPTH);

    loader_state_t       r_state;
    loader_state_t       w_next_state;
    logic [c_CNT_W-1:0]  r_word_cnt;
    logic                r_wr_en;
    logic [ADDR_W-1:0]   r_wr_addr;
    logic [WORD_W-1:0]   r_wr_data;
    logic                w_ser_ready;
    logic                w_busy;
    logic                w_done;
    logic                w_error;
    logic                w_accept;
    logic                w_start_load;
    logic                w_load_full;
    logic                w_word_valid;
    logic [WORD_W-1:0]   w_word;
`ifdef PROG_LOADER_CHECKSUM_EN
    logic [WORD_W-1:0]   r_sum;
`endif

    assign w_load_full  = (r_word_cnt == c_DEPTH_CNT);
    assign w_accept     = bus.ser_valid & w_ser_ready;
    assign w_start_load = bus.start &
                          ((r_state == ST_IDLE) || (r_state == ST_DONE) || (r_state == ST_ERROR));

    prog_loader_deser u_deser (
        .clock        (clock),
        .reset_n      (reset_n),
        .i_clear      (w_start_load),
        .i_bit        (bus.ser_bit),
        .i_bit_en     (w_accept),
        .o_word_valid (w_word_valid),
        .o_word       (w_word)
    );

    always_ff @(posedge clock) begin
        if (!reset_n) r_state <= ST_IDLE;
        else          r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        w_ser_ready  = 1'b0;
        w_busy       = 1'b0;
        w_done       = 1'b0;
        w_error      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.start) w_next_state = ST_LOAD;
            end
            ST_LOAD: begin
                w_busy      = 1'b1;
                // Full while the final write pulse is out: no bit may slip in before leaving LOAD
                w_ser_ready = !w_load_full;
`ifdef PROG_LOADER_CHECKSUM_EN
                if (w_load_full) w_next_state = ST_CHECK;
`else
                if (w_load_full) w_next_state = ST_DONE;
`endif
            end
`ifdef PROG_LOADER_CHECKSUM_EN
            ST_CHECK: begin
                w_busy      = 1'b1;
                w_ser_ready = 1'b1;
                if (w_word_valid) w_next_state = (w_word == r_sum) ? ST_DONE : ST_ERROR;
            end
            ST_ERROR: begin
                w_error = 1'b1;
                if (bus.start) w_next_state = ST_LOAD;
            end
`endif
            ST_DONE: begin
                w_done = 1'b1;
                if (bus.start) w_next_state = ST_LOAD;
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_word_cnt <= '0;
            r_wr_en    <= 1'b0;
            r_wr_addr  <= '0;
            r_wr_data  <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
            r_sum      <= '0;
`endif
        end else begin
            r_wr_en <= 1'b0;
            if (w_start_load) begin
                r_word_cnt <= '0;
                r_wr_addr  <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
                r_sum      <= '0;
`endif
            end else if ((r_state == ST_LOAD) && w_word_valid) begin
                r_wr_en    <= 1'b1;
                r_wr_addr  <= ADDR_W'(r_word_cnt);
                r_wr_data  <= w_word;
                r_word_cnt <= r_word_cnt + 1'b1;
`ifdef PROG_LOADER_CHECKSUM_EN
                r_sum      <= r_sum + w_word;
`endif
            end
        end
    end

    assign bus.ser_ready = w_ser_ready;
    assign bus.wr_en     = r_wr_en;
    assign bus.wr_addr   = r_wr_addr;
    assign bus.wr_data   = r_wr_data;
    assign bus.busy      = w_busy;
    assign bus.done      = w_done;
    assign bus.cpu_run   = w_done;
    assign bus.error     = w_error;

endmodule

`default_nettype wire
